// File: rtl/core_test_harness_pkg.sv
// core_test_harness_pkg: shared state encoding, status codes and defaults for the test harness.
package core_test_harness_pkg;
    localparam logic [2:0] ST_HOLD    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [1:0] STAT_BUSY    = 2'b00;
    localparam logic [1:0] STAT_PASS    = 2'b01;
    localparam logic [1:0] STAT_FAIL    = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;
    localparam int TOHOST_REG_DEFAULT = 31;
    function automatic logic [1:0] state_status(input logic [2:0] s);
        return s == ST_PASS ? STAT_PASS : s == ST_FAIL ? STAT_FAIL :
               s == ST_TIMEOUT ? STAT_TIMEOUT : STAT_BUSY;
    endfunction
endpackage

// File: rtl/core_test_harness_sig_fifo.sv
// sig_fifo: signature FIFO with extra pointer bit for full/empty; push while full is accepted only alongside a pop.
module sig_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;
    always_comb begin
        empty = wr_q == rd_q;
        full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
        rd_data = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/core_test_harness.sv
// core_test_harness: holds the core in reset, watches writebacks for tohost/timeout and records a signature FIFO.
module core_test_harness
    import core_test_harness_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 1000,
    parameter int TOHOST_REG = TOHOST_REG_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    output logic            core_rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            sig_valid,
    input  logic            sig_ready,
    output logic [XLEN+4:0] sig_data,
    output logic [1:0]      status,
    output logic            done,
    output logic [31:0]     cycle_count,
    output logic [31:0]     retire_count,
    output logic            overflow
);
    localparam logic [4:0]  TOHOST    = 5'(TOHOST_REG);
    localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] CYC_LAST  = 32'(MAX_CYCLES - 1);
    logic [2:0] state_q, state_d;
    logic [31:0] hold_q, hold_d, cycle_q, cycle_d, retire_q, retire_d;
    logic overflow_q, overflow_d;
    logic run, wb_run, term, push, pop, full, empty;
    always_comb begin
        run = state_q == ST_RUN;
        wb_run = run && wb_valid;
        term = wb_run && wb_rd == TOHOST && wb_data != '0;
        push = wb_run && wb_rd != 5'd0;
        pop = !empty && sig_ready && state_q != ST_HOLD;
        hold_d = state_q == ST_HOLD ? hold_q + 32'd1 : hold_q;
        // the timeout cycle itself does not advance the count, so it freezes at MAX_CYCLES-1
        cycle_d = (run && cycle_q != CYC_LAST) ? cycle_q + 32'd1 : cycle_q;
        retire_d = (wb_run && retire_q != '1) ? retire_q + 32'd1 : retire_q;
        overflow_d = overflow_q || (push && full && !pop);
        state_d = state_q;
        if (state_q == ST_HOLD && hold_q == HOLD_LAST) state_d = ST_RUN;
        else if (term) state_d = wb_data == XLEN'(1) ? ST_PASS : ST_FAIL;
        else if (run && cycle_q == CYC_LAST) state_d = ST_TIMEOUT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HOLD;
            hold_q <= '0;
            cycle_q <= '0;
            retire_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            cycle_q <= cycle_d;
            retire_q <= retire_d;
            overflow_q <= overflow_d;
        end
    end
    sig_fifo #(.WIDTH(XLEN + 5), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst),
        .push(push),
        .pop(pop),
        .wr_data({wb_rd, wb_data}),
        .rd_data(sig_data),
        .full(full),
        .empty(empty)
    );
    assign core_rst = state_q != ST_HOLD;
    assign status = state_status(state_q);
    assign done = status != STAT_BUSY;
    assign sig_valid = !empty;
    assign cycle_count = cycle_q;
    assign retire_count = retire_q;
    assign overflow = overflow_q;
endmodule

// File: doc/core_test_harness.md
CORE_TEST_HARNESS -- requirements
Module: core_test_harness

Interface
REQ-001 SHALL have parameter XLEN, default 32: writeback data width.
REQ-002 SHALL have parameter DEPTH, default 16: signature FIFO entries, power of two, >= 2.
REQ-003 SHALL have parameter RST_CYCLES, default 2: cycles core_rst is held low after rst release, >= 1.
REQ-004 SHALL have parameter MAX_CYCLES, default 1000: RUN-cycle timeout limit.
REQ-005 SHALL have parameter TOHOST_REG, default 31: end-of-test destination register.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-008 SHALL have port core_rst  output  1  active-low reset driven to the core under test.
REQ-009 SHALL have ports wb_valid input 1, wb_rd input 5 and wb_data input XLEN: core writeback strobe, destination register and data.
REQ-010 SHALL have ports sig_valid output 1, sig_ready input 1 and sig_data output XLEN+5: signature readback {rd, data}.
REQ-011 SHALL have ports status output 2 (00 busy, 01 PASS, 10 FAIL, 11 TIMEOUT) and done output 1.
REQ-012 SHALL have ports cycle_count output 32, retire_count output 32 and overflow output 1 (sticky).

Function
REQ-013 FSM states SHALL be HOLD, RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT are terminal until rst.
REQ-014 HOLD SHALL keep core_rst=0 for exactly RST_CYCLES clk edges after rst rises, then enter RUN with core_rst=1 from the next cycle on.
REQ-015 In RUN, a write with wb_valid=1, wb_rd=TOHOST_REG and wb_data=1 SHALL move the FSM to PASS on the next edge.
REQ-016 In RUN, a write to TOHOST_REG with wb_data not in {0,1} SHALL move the FSM to FAIL; a data value of 0 is an ordinary write.
REQ-017 In RUN, cycle_count SHALL increment once per cycle; when cycle_count==MAX_CYCLES-1 and no terminating tohost write occurs, the FSM SHALL enter TIMEOUT.
REQ-018 A terminating tohost write in the same cycle as the timeout SHALL take priority: result PASS or FAIL.
REQ-019 cycle_count SHALL freeze in terminal states, and core_rst SHALL remain 1 in terminal states.
REQ-020 retire_count SHALL increment on every wb_valid in RUN, including rd=0 and tohost writes, and SHALL saturate at all ones.
REQ-021 A write in RUN with wb_valid=1 and wb_rd!=0 SHALL push {wb_rd, wb_data} into the FIFO; writes to rd=0 are not recorded.
REQ-022 The terminating tohost write SHALL itself be pushed.
REQ-023 sig_valid SHALL equal FIFO not-empty; sig_data SHALL show the head entry combinationally; a pop occurs when sig_valid and sig_ready are both 1.
REQ-024 Draining SHALL be allowed in every state except HOLD.
REQ-025 A push while the FIFO is full and no pop occurs SHALL drop the entry and set overflow, which stays 1 until rst.
REQ-026 A push and a pop in the same cycle SHALL both be accepted, whether the FIFO is full or not, and leave the occupancy unchanged.
REQ-027 wb_* inputs SHALL be ignored in HOLD and in terminal states.
REQ-028 done SHALL be 1 exactly when the FSM is in PASS, FAIL or TIMEOUT; status SHALL be 00 in HOLD and RUN.

Reset
REQ-029 rst=0 SHALL asynchronously force FSM=HOLD, core_rst=0, cycle_count=0, retire_count=0, FIFO empty, sig_valid=0, overflow=0, status=00 and done=0.
REQ-030 rst asserted mid-run or in a terminal state SHALL discard all FIFO contents and restart the HOLD sequence when rst is released.

Structure
REQ-031 A shared package SHALL hold the state encoding, the status codes (STAT_BUSY, STAT_PASS, STAT_FAIL, STAT_TIMEOUT) and the default TOHOST_REG.
REQ-032 The FIFO SHALL be one sub-module, sig_fifo, parametrised by WIDTH and DEPTH and providing push, pop, full and empty; its pointers SHALL be one bit wider than log2(DEPTH) for wrap detection.

Verification
REQ-033 Scenario: rst low 3 cycles, then high -> core_rst 0 for exactly 2 edges, then 1; status=00.
REQ-034 Scenario: writes x5=0xA, x0=0x7, x31=1 -> FIFO holds {5,0xA} and {31,1}; retire_count=3; status=01 and done=1 on the next edge.
REQ-035 Scenario: write x31=0xDEAD -> status=10; a later write x6=0x1 is neither recorded nor counted.
REQ-036 Scenario: MAX_CYCLES=20 with no tohost write -> status=11 after 20 RUN cycles; cycle_count=19 and frozen.
REQ-037 Scenario: DEPTH=4, sig_ready=0, 5 writes to x1..x5 -> overflow=1 and FIFO holds x1..x4; with sig_ready=1 while full plus one push, occupancy stays 4 and the order is preserved.
REQ-038 Scenario: tohost write x31=1 on the timeout cycle -> status=01; rst pulse mid-run -> all outputs return to their reset values immediately.
